filter_accum4: RTL and testbench

FILTER_ACCUM4 -- requirements
Module: filter_accum4

---
 rtl/filter_accum4_if.sv | 37 +++
 rtl/filter_accum4.sv | 117 +++++++++++
 tb/tb_filter_accum4.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_accum4_if.sv
// filter_accum4_if
//   Groups the tap-set input handshake and the filtered-sample output
//   handshake of filter_accum4 into one bundle.
//   slave  : view of the filter itself
//   master : view of whoever drives taps and consumes samples
//
//   P0..P3     signed 16-bit tap products (reference sample x coefficient)
//   in_valid   P0..P3 hold a valid tap set
//   in_ready   filter accepts a tap set this cycle
//   out_sample filtered, rounded, clipped 8-bit sample
//   out_valid  out_sample is valid
//   out_ready  consumer accepts out_sample
//   out_last   out_sample is the last sample of its row
//   row_cnt    index of out_sample within its row
interface filter_accum4_if;
  logic signed [15:0] P0;
  logic signed [15:0] P1;
  logic signed [15:0] P2;
  logic signed [15:0] P3;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         out_sample;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [5:0]         row_cnt;

  modport slave (
    input  P0, P1, P2, P3, in_valid, out_ready,
    output in_ready, out_sample, out_valid, out_last, row_cnt
  );

  modport master (
    output P0, P1, P2, P3, in_valid, out_ready,
    input  in_ready, out_sample, out_valid, out_last, row_cnt
  );
endinterface

// File: rtl/filter_accum4.sv
// filter_accum4
//   Sums four signed tap products, rounds, divides by 64 and clips to an
//   unsigned 8-bit predicted sample. Three-stage pipeline with a valid bit
//   per stage; the whole pipeline freezes while the output is stalled, so
//   bubbles are kept in place rather than squeezed out.
//   Output samples are grouped into rows of ROW_LEN; row_cnt gives the
//   position of the presented sample and out_last flags the row end.
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  filter_accum4_if.slave (taps in, samples out, both handshaked)
module filter_accum4 #(
  parameter int ROW_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  filter_accum4_if.slave  bus
);

  localparam logic [5:0] LAST_IDX = 6'(ROW_LEN - 1);

  logic               w_stall;
  logic               w_adv;
  logic               w_xfer;
  logic signed [18:0] w_shift;
  logic [7:0]         w_clip;

  logic               r_v1;
  logic               r_v2;
  logic               r_v3;
  logic signed [16:0] r_s01;
  logic signed [16:0] r_s23;
  logic signed [18:0] r_acc;
  logic [7:0]         r_sample;
  logic [5:0]         r_row_cnt;

  // A stall is only possible when stage 3 holds a sample the consumer refuses;
  // every stage advances together otherwise.
  assign w_stall = r_v3 & ~bus.out_ready;
  assign w_adv   = ~w_stall;
  assign w_xfer  = r_v3 & bus.out_ready;

  // Stage 1: pairwise sums, sign-extended to 17 bits so they cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_s01 <= '0;
      r_s23 <= '0;
    end else if (w_adv) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_s01 <= {bus.P0[15], bus.P0} + {bus.P1[15], bus.P1};
        r_s23 <= {bus.P2[15], bus.P2} + {bus.P3[15], bus.P3};
      end
    end
  end

  // Stage 2: full sum plus rounding constant (half of 64) in 19 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_acc <= '0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_acc <= {{2{r_s01[16]}}, r_s01} + {{2{r_s23[16]}}, r_s23} + 19'sd32;
      end
    end
  end

  // Divide by 64 with floor semantics, then saturate into 0..255.
  assign w_shift = r_acc >>> 6;

  always_comb begin
    w_clip = w_shift[7:0];
    if (w_shift[18]) begin
      w_clip = 8'd0;
    end else if (|w_shift[17:8]) begin
      w_clip = 8'hFF;
    end
  end

  // Stage 3: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3     <= 1'b0;
      r_sample <= '0;
    end else if (w_adv) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_sample <= w_clip;
      end
    end
  end

  // row_cnt names the sample currently presented, so it only moves once that
  // sample has actually been taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_cnt <= '0;
    end else if (w_xfer) begin
      if (r_row_cnt == LAST_IDX) begin
        r_row_cnt <= '0;
      end else begin
        r_row_cnt <= r_row_cnt + 6'd1;
      end
    end
  end

  assign bus.in_ready   = w_adv;
  assign bus.out_valid  = r_v3;
  assign bus.out_sample = r_sample;
  assign bus.out_last   = r_v3 & (r_row_cnt == LAST_IDX);
  assign bus.row_cnt    = r_row_cnt;

endmodule

// File: tb/tb_filter_accum4.sv
module tb_filter_accum4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  filter_accum4_if bus ();
  filter_accum4_if bus1 ();

  filter_accum4 #(.ROW_LEN(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  filter_accum4 #(.ROW_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // The single-sample-row instance sees exactly the same stimulus.
  assign bus1.P0        = bus.P0;
  assign bus1.P1        = bus.P1;
  assign bus1.P2        = bus.P2;
  assign bus1.P3        = bus.P3;
  assign bus1.in_valid  = bus.in_valid;
  assign bus1.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // Reference: integer sum of the four taps, add half an LSB, floor-divide by 64, saturate.
  function automatic logic [7:0] ref_pix(input int a, input int b, input int c, input int d);
    int q;
    q = (a + b + c + d + 32) >>> 6;
    if (q < 0) return 8'd0;
    if (q > 255) return 8'd255;
    return 8'(q);
  endfunction

  function automatic int rand_tap();
    logic signed [15:0] t;
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 8191)) - 2048;
    t = 16'($urandom);
    return int'(t);
  endfunction

  task automatic drive(input int a, input int b, input int c, input int d);
    bus.P0 = 16'(a);
    bus.P1 = 16'(b);
    bus.P2 = 16'(c);
    bus.P3 = 16'(d);
    bus.in_valid = 1'b1;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(rand_tap(), rand_tap(), rand_tap(), rand_tap());
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_sample !== 8'd0) begin n_fail++; $display("FAIL reset_out_sample got=%0d exp=0", bus.out_sample); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
    n_checks++; if (bus.row_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_row_cnt got=%0d exp=0", bus.row_cnt); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    // Tap sets offered while rst was high must never emerge.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_priority k=%0d out_valid got=%b exp=0", k, bus.out_valid); end
    end
  endtask

  task automatic test_smoothing;
    reset_dut();
    drive(1600, 3200, 1600, 0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL smooth_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL smooth_latency cycle=%0d out_valid got=%b exp=0", k, bus.out_valid); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL smooth_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_sample !== 8'd100) begin n_fail++; $display("FAIL smooth_sample got=%0d exp=100", bus.out_sample); end
    n_checks++; if (bus.row_cnt !== 6'd0) begin n_fail++; $display("FAIL smooth_row_cnt got=%0d exp=0", bus.row_cnt); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL smooth_last got=%b exp=0", bus.out_last); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL smooth_drain out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_clipping;
    int vec [4][5];
    vec = '{'{-100, 0, 0, 0, 0}, '{32767, 32767, 32767, 32767, 255},
            '{0, 0, 0, 31, 0}, '{0, 0, 0, 32, 1}};
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL clip_valid vec=%0d got=%b exp=1", i, bus.out_valid); end
      n_checks++; if (bus.out_sample !== 8'(vec[i][4])) begin n_fail++; $display("FAIL clip_sample vec=%0d got=%0d exp=%0d", i, bus.out_sample, vec[i][4]); end
      @(negedge clk);
    end
  endtask

  task automatic test_streaming;
    int taps [8][4];
    logic [7:0] expv [8];
    int j;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) taps[i][k] = rand_tap();
      expv[i] = ref_pix(taps[i][0], taps[i][1], taps[i][2], taps[i][3]);
    end
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(taps[i][0], taps[i][1], taps[i][2], taps[i][3]);
      else bus.in_valid = 1'b0;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", i, bus.in_ready); end
      if (i >= 3 && i <= 10) begin
        j = i - 3;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid out=%0d got=%b exp=1", j, bus.out_valid); end
        n_checks++; if (bus.out_sample !== expv[j]) begin n_fail++; $display("FAIL stream_sample out=%0d got=%0d exp=%0d", j, bus.out_sample, expv[j]); end
        n_checks++; if (bus.row_cnt !== 6'(j % 4)) begin n_fail++; $display("FAIL stream_row_cnt out=%0d got=%0d exp=%0d", j, bus.row_cnt, j % 4); end
        n_checks++; if (bus.out_last !== ((j % 4) == 3)) begin n_fail++; $display("FAIL stream_last out=%0d got=%b exp=%b", j, bus.out_last, (j % 4) == 3); end
      end else begin
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle cyc=%0d out_valid got=%b exp=0", i, bus.out_valid); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_q[$];
    logic [7:0] pend_exp;
    logic pend;
    int sent, got, stall_left, first, stalled;
    int t0, t1, t2, t3;
    pend = 1'b0; sent = 0; got = 0; stall_left = 0; first = -1; stalled = 0;
    reset_dut();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (first < 0 && bus.out_valid === 1'b1) begin first = cyc; stall_left = 5; end
      bus.out_ready = (stall_left == 0);
      if (!pend && sent < 6) begin
        t0 = rand_tap(); t1 = rand_tap(); t2 = rand_tap(); t3 = rand_tap();
        drive(t0, t1, t2, t3);
        pend_exp = ref_pix(t0, t1, t2, t3);
        pend = 1'b1;
      end else if (!pend) begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        stalled++;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b1 || exp_q.size() == 0 || bus.out_sample !== exp_q[0]) begin
          n_fail++; $display("FAIL bp_hold cyc=%0d valid=%b sample=%0d exp=%0d", cyc, bus.out_valid, bus.out_sample, (exp_q.size() > 0) ? exp_q[0] : 8'd0);
        end
        n_checks++; if (bus.row_cnt !== 6'd0) begin n_fail++; $display("FAIL bp_hold_row cyc=%0d got=%0d exp=0", cyc, bus.row_cnt); end
        stall_left--;
      end else begin
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=1", cyc, bus.in_ready); end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_checks++; if (exp_q.size() == 0 || bus.out_sample !== exp_q[0]) begin
          n_fail++; $display("FAIL bp_order out=%0d got=%0d exp=%0d", got, bus.out_sample, (exp_q.size() > 0) ? exp_q[0] : 8'd0);
        end
        n_checks++; if (bus.row_cnt !== 6'(got % 4) || bus.out_last !== ((got % 4) == 3)) begin
          n_fail++; $display("FAIL bp_row out=%0d row_cnt=%0d last=%b exp_row=%0d", got, bus.row_cnt, bus.out_last, got % 4);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        exp_q.push_back(pend_exp);
        pend = 1'b0;
        sent++;
      end
      @(negedge clk);
    end
    n_checks++; if (got != 6) begin n_fail++; $display("FAIL bp_count got=%0d exp=6", got); end
    n_checks++; if (stalled != 5) begin n_fail++; $display("FAIL bp_stall_cycles got=%0d exp=5", stalled); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      drive(1280 * (i + 2), 0, 0, 0);
      @(negedge clk);
    end
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill out_valid got=%b exp=1", bus.out_valid); end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.row_cnt !== 6'd0) begin n_fail++; $display("FAIL mid_row_cnt got=%0d exp=0", bus.row_cnt); end
    n_checks++; if (bus.out_sample !== 8'd0) begin n_fail++; $display("FAIL mid_out_sample got=%0d exp=0", bus.out_sample); end
    rst = 1'b0;
    drive(640, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_flushed cycle=%0d out_valid got=%b exp=0", k, bus.out_valid); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_sample !== 8'd10) begin
      n_fail++; $display("FAIL mid_next valid=%b sample=%0d exp_valid=1 exp_sample=10", bus.out_valid, bus.out_sample);
    end
    n_checks++; if (bus.row_cnt !== 6'd0) begin n_fail++; $display("FAIL mid_next_row got=%0d exp=0", bus.row_cnt); end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] q1[$];
    logic [7:0] e;
    int got;
    int t0, t1, t2, t3;
    got = 0;
    reset_dut();
    for (int cyc = 0; cyc < 10010; cyc++) begin
      t0 = rand_tap(); t1 = rand_tap(); t2 = rand_tap(); t3 = rand_tap();
      bus.P0 = 16'(t0); bus.P1 = 16'(t1); bus.P2 = 16'(t2); bus.P3 = 16'(t3);
      if (cyc < 10000) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
      end
      e = ref_pix(t0, t1, t2, t3);
      #1;
      n_checks++; if (bus.in_ready !== ~(bus.out_valid & ~bus.out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%b valid=%b ready=%b", cyc, bus.in_ready, bus.out_valid, bus.out_ready);
      end
      if (bus.out_valid === 1'b1) begin
        n_checks++; if (q.size() == 0 || bus.out_sample !== q[0]) begin
          n_fail++; $display("FAIL rnd_sample cyc=%0d got=%0d exp=%0d pending=%0d", cyc, bus.out_sample, (q.size() > 0) ? q[0] : 8'd0, q.size());
        end
        n_checks++; if (bus.row_cnt !== 6'(got % 4) || bus.out_last !== ((got % 4) == 3)) begin
          n_fail++; $display("FAIL rnd_row cyc=%0d row_cnt=%0d last=%b exp_row=%0d", cyc, bus.row_cnt, bus.out_last, got % 4);
        end
      end else begin
        n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rnd_last_idle cyc=%0d got=%b exp=0", cyc, bus.out_last); end
      end
      if (bus1.out_valid === 1'b1) begin
        n_checks++; if (q1.size() == 0 || bus1.out_sample !== q1[0] || bus1.out_last !== 1'b1 || bus1.row_cnt !== 6'd0) begin
          n_fail++; $display("FAIL rnd_row1 cyc=%0d sample=%0d exp=%0d last=%b row_cnt=%0d", cyc, bus1.out_sample, (q1.size() > 0) ? q1[0] : 8'd0, bus1.out_last, bus1.row_cnt);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
      if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1 && q1.size() > 0) void'(q1.pop_front());
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) q.push_back(e);
      if (bus1.in_valid === 1'b1 && bus1.in_ready === 1'b1) q1.push_back(e);
      @(negedge clk);
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain left=%0d exp=0", q.size()); end
    n_checks++; if (q1.size() != 0) begin n_fail++; $display("FAIL rnd_drain_row1 left=%0d exp=0", q1.size()); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.P0 = '0; bus.P1 = '0; bus.P2 = '0; bus.P3 = '0;
    test_reset();
    test_smoothing();
    test_clipping();
    test_streaming();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
